seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Sequential decoder for the multiplexed 4-digit seven-segment display bus driven by the team's hex-to-segment encoder and anode scanner. Samples active-low anode and segment lines, filters scan transitions and glitches, maps each stable segment pattern back to a hex nibble, and assembles a complete 4-digit frame. Used as an on-chip loopback checker and as a display-readback source for debug logic.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (min 2).
- TIMEOUT_CYCLES, 1000000: idle cycles without an accept before a partial frame is discarded and `valid` is dropped.

- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- an  input  4  anode enables, active low; an[0] is the rightmost digit
- seg  input  7  segments, active low, seg[0]=a … seg[6]=g
- value  output  16  last complete frame; an[k] digit maps to value[4k+3:4k]
- valid  output  1  `value` holds a frame published since reset or timeout
- err  output  1  last published frame contained an undecodable pattern
- frame_done  output  1  one-cycle pulse when `value` updates
- digit_mask  output  4  digits captured in the frame under assembly

## Operation
- Reset (rst_n=0 at an edge): value=16'h0000, valid=0, err=0, frame_done=0, digit_mask=4'b0000, all counters 0, state EMPTY.
- Input stage: {an,seg} is registered every cycle. The stability counter increments while the registered sample equals the previous one, saturating at STABLE_CYCLES. Any difference clears it to 0.
- Accept: fires once per stable period, on the cycle the counter reaches STABLE_CYCLES. It requires `an` to have exactly one bit low. `an`=4'b1111 (blanking) and patterns with more than one low bit never accept and do not alter frame state.
- Decode (seg, active low): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0111111→A (dash glyph), 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F. Any other pattern gives nibble 0 and sets that digit's bad flag.
- On accept: write the nibble into the shadow register slot for the low anode, set the matching digit_mask bit, and record the bad flag. Re-accepting a digit already captured in this frame overwrites its nibble and flag (latest wins) and raises no error.
- States:
  - EMPTY: digit_mask=0. An accept moves to COLLECT.
  - COLLECT: accepts add digits. When an accept makes digit_mask 4'b1111, go to PUBLISH.
  - PUBLISH: lasts one cycle. value←shadow, valid←1, err←OR of bad flags, frame_done=1. digit_mask, shadow flags and bad flags clear. Return to EMPTY.
- Timeout: an idle counter runs in COLLECT and clears on each accept. When it reaches TIMEOUT_CYCLES: digit_mask←0, valid←0, return to EMPTY. `value` and `err` are retained. EMPTY never times out.
- Reset mid-frame discards shadow contents immediately; no frame_done.

## Timing
- E0 is the first edge that registers a new {an,seg}. If the input holds through E(STABLE_CYCLES−1), the accept takes effect at edge E(STABLE_CYCLES), and digit_mask updates then.
- The completing accept is followed by PUBLISH. value, valid and err update, and frame_done is high, for exactly the cycle after edge E(STABLE_CYCLES)+1.
- Input held for fewer than STABLE_CYCLES samples produces no accept.
- A held pattern accepts only once, however long it persists.
- Outputs are registered. No combinational path from an or seg to any output.

## Test plan
- Scan value 16'h1234: an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001, 8 cycles each -> single frame_done pulse; value=16'h1234, valid=1, err=0, digit_mask back to 0.
- Same scan with 2-cycle an=1111 blanking between digits, plus a 3-cycle glitch an=1101/seg=0000000 before digit 1 -> value=16'h1234; glitch not accepted.
- Digit 2 driven seg=1111111, others 5, A (0111111), F -> value with nibble 2 = 0 and the other nibbles decoded as sent, err=1, valid=1; next clean frame 16'hABCD -> err=0.
- an=1100 with any seg for 20 cycles -> digit_mask unchanged, no frame_done.
- TIMEOUT_CYCLES=50: capture 2 digits after a published frame, then hold an=1111 -> at idle count 50, digit_mask=0, valid=0, value unchanged.
- Assert rst_n=0 for one edge after 3 digits captured -> all outputs at reset values; a following full scan publishes normally.

Source files
------------

// File: rtl/seven_seg_capture_if.sv
// Bundle of display-bus inputs and captured-frame outputs for seven_seg_capture.
// The master drives the scanned display lines. The slave (the capture block) returns the decoded frame.
interface seven_seg_capture_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic        frame_done;
    logic [3:0]  digit_mask;

    modport master (
        output an,
        output seg,
        input  value,
        input  valid,
        input  err,
        input  frame_done,
        input  digit_mask
    );

    modport slave (
        input  an,
        input  seg,
        output value,
        output valid,
        output err,
        output frame_done,
        output digit_mask
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Reads back a multiplexed active-low 4-digit seven-segment bus and reassembles the shown hex value.
// Each digit must be stable for STABLE_CYCLES samples before it is decoded.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic              clk,
    input logic              rst_n,
    seven_seg_capture_if.slave bus
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] ACCEPT_AT = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    logic [10:0]       sample_q;
    logic [STAB_W-1:0] stab_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [1:0]        state;
    logic [15:0]       shadow;
    logic [3:0]        bad_q;
    logic [3:0]        mask_q;
    logic [15:0]       value_q;
    logic              valid_q;
    logic              err_q;
    logic              fd_q;

    logic [3:0] sample_an;
    logic [6:0] sample_seg;
    logic       one_low;
    logic [1:0] slot;
    logic [3:0] slot_bit;
    logic [3:0] nibble;
    logic       digit_bad;
    logic       accept;

    assign sample_an  = sample_q[10:7];
    assign sample_seg = sample_q[6:0];

    // The counter tracks how many consecutive edges registered the same {an,seg}.
    // It therefore reads STABLE_CYCLES-1 once STABLE_CYCLES identical samples have been taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= '1;
            stab_cnt <= '0;
        end else begin
            sample_q <= {bus.an, bus.seg};
            if ({bus.an, bus.seg} == sample_q) begin
                if (stab_cnt != STAB_MAX)
                    stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_comb begin
        one_low = 1'b1;
        slot    = 2'd0;
        case (sample_an)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign slot_bit = ~sample_an;
    assign accept   = one_low && (stab_cnt == ACCEPT_AT);

    always_comb begin
        nibble    = 4'h0;
        digit_bad = 1'b0;
        case (sample_seg)
            7'b1000000: nibble = 4'h0;
            7'b1111001: nibble = 4'h1;
            7'b0100100: nibble = 4'h2;
            7'b0110000: nibble = 4'h3;
            7'b0011001: nibble = 4'h4;
            7'b0010010: nibble = 4'h5;
            7'b0000010: nibble = 4'h6;
            7'b1111000: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0010000: nibble = 4'h9;
            7'b0111111: nibble = 4'hA;
            7'b0000011: nibble = 4'hB;
            7'b1000110: nibble = 4'hC;
            7'b0100001: nibble = 4'hD;
            7'b0000110: nibble = 4'hE;
            7'b0001110: nibble = 4'hF;
            default:    digit_bad = 1'b1;
        endcase
    end

    // Frame assembly. No accept can arrive during PUBLISH.
    // The stability counter cannot return to STABLE_CYCLES-1 within one cycle of an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            idle_cnt <= '0;
            shadow   <= '0;
            bad_q    <= '0;
            mask_q   <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        shadow[{slot, 2'b00} +: 4] <= nibble;
                        bad_q[slot]                <= digit_bad;
                        mask_q                     <= mask_q | slot_bit;
                        idle_cnt                   <= '0;
                        state                      <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        shadow[{slot, 2'b00} +: 4] <= nibble;
                        bad_q[slot]                <= digit_bad;
                        mask_q                     <= mask_q | slot_bit;
                        idle_cnt                   <= '0;
                        if ((mask_q | slot_bit) == 4'b1111)
                            state <= ST_PUBLISH;
                    end else if (idle_cnt == IDLE_LAST) begin
                        mask_q   <= '0;
                        bad_q    <= '0;
                        valid_q  <= 1'b0;
                        idle_cnt <= '0;
                        state    <= ST_EMPTY;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    value_q  <= shadow;
                    valid_q  <= 1'b1;
                    err_q    <= |bad_q;
                    fd_q     <= 1'b1;
                    mask_q   <= '0;
                    bad_q    <= '0;
                    idle_cnt <= '0;
                    state    <= ST_EMPTY;
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.value      = value_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.frame_done = fd_q;
    assign bus.digit_mask = mask_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with STABLE_CYCLES=4 and TIMEOUT_CYCLES=50.
// Expected frames are hand-computed from the digits each scenario sends.
module tb_seven_seg_capture;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_A   = 7'b0111111;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   fd_count = 0;
    logic fd_prev = 1'b0;

    seven_seg_capture_if bus ();

    seven_seg_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // frame_done must never be high on two consecutive samples
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            fd_count++;
            vectors++;
            if (fd_prev === 1'b1) begin
                miscompares++;
                $display("[TB] FAIL frame_done_width: high 2 cycles, required 1");
            end
        end
        fd_prev = bus.frame_done;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int blank);
        hold(4'b1110, s0, 8);
        if (blank > 0) hold(4'b1111, SEG_BAD, blank);
        hold(4'b1101, s1, 8);
        if (blank > 0) hold(4'b1111, SEG_BAD, blank);
        hold(4'b1011, s2, 8);
        if (blank > 0) hold(4'b1111, SEG_BAD, blank);
        hold(4'b0111, s3, 8);
        hold(4'b1111, SEG_BAD, 4);
    endtask

    task automatic test_reset;
        bus.an  = 4'b1111;
        bus.seg = SEG_BAD;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vectors += 5;
        if (bus.value !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_value: got %h required 0000", bus.value); end
        if (bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b required 0", bus.valid); end
        if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b required 0", bus.err); end
        if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b required 0", bus.frame_done); end
        if (bus.digit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_mask: got %b required 0000", bus.digit_mask); end
    endtask

    task automatic test_basic_scan;
        int fd0;
        fd0 = fd_count;
        hold(4'b1110, SEG_4, 8);
        vectors++;
        if (bus.digit_mask !== 4'b0001) begin miscompares++; $display("[TB] FAIL basic_partial_mask: got %b required 0001", bus.digit_mask); end
        hold(4'b1101, SEG_3, 8);
        hold(4'b1011, SEG_2, 8);
        hold(4'b0111, SEG_1, 8);
        hold(4'b1111, SEG_BAD, 4);
        vectors += 5;
        if (fd_count - fd0 !== 1) begin miscompares++; $display("[TB] FAIL basic_pulses: got %0d required 1", fd_count - fd0); end
        if (bus.value !== 16'h1234) begin miscompares++; $display("[TB] FAIL basic_value: got %h required 1234", bus.value); end
        if (bus.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %b required 1", bus.valid); end
        if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_err: got %b required 0", bus.err); end
        if (bus.digit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL basic_mask: got %b required 0000", bus.digit_mask); end
    endtask

    task automatic test_blank_glitch;
        int fd0;
        fd0 = fd_count;
        hold(4'b1110, SEG_4, 8);
        hold(4'b1111, SEG_BAD, 2);
        hold(4'b1101, SEG_8, 3);
        hold(4'b1111, SEG_BAD, 2);
        vectors++;
        if (bus.digit_mask !== 4'b0001) begin miscompares++; $display("[TB] FAIL glitch_mask: got %b required 0001", bus.digit_mask); end
        hold(4'b1101, SEG_3, 8);
        hold(4'b1111, SEG_BAD, 2);
        hold(4'b1011, SEG_2, 8);
        hold(4'b1111, SEG_BAD, 2);
        hold(4'b0111, SEG_1, 8);
        hold(4'b1111, SEG_BAD, 4);
        vectors += 2;
        if (bus.value !== 16'h1234) begin miscompares++; $display("[TB] FAIL glitch_value: got %h required 1234", bus.value); end
        if (fd_count - fd0 !== 1) begin miscompares++; $display("[TB] FAIL glitch_pulses: got %0d required 1", fd_count - fd0); end
    endtask

    task automatic test_bad_digit;
        scan(SEG_F, SEG_A, SEG_BAD, SEG_5, 0);
        vectors += 3;
        if (bus.value !== 16'h50AF) begin miscompares++; $display("[TB] FAIL bad_value: got %h required 50af", bus.value); end
        if (bus.err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_err: got %b required 1", bus.err); end
        if (bus.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_valid: got %b required 1", bus.valid); end
        scan(SEG_D, SEG_C, SEG_B, SEG_A, 2);
        vectors += 2;
        if (bus.value !== 16'hABCD) begin miscompares++; $display("[TB] FAIL clean_value: got %h required abcd", bus.value); end
        if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_err: got %b required 0", bus.err); end
    endtask

    task automatic test_multi_low;
        int fd0;
        fd0 = fd_count;
        hold(4'b1100, SEG_1, 20);
        vectors += 2;
        if (bus.digit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL multi_empty_mask: got %b required 0000", bus.digit_mask); end
        if (fd_count - fd0 !== 0) begin miscompares++; $display("[TB] FAIL multi_empty_pulses: got %0d required 0", fd_count - fd0); end
        hold(4'b1110, SEG_4, 8);
        hold(4'b1100, SEG_8, 20);
        vectors++;
        if (bus.digit_mask !== 4'b0001) begin miscompares++; $display("[TB] FAIL multi_mid_mask: got %b required 0001", bus.digit_mask); end
        hold(4'b1101, SEG_3, 8);
        hold(4'b1011, SEG_2, 8);
        hold(4'b0111, SEG_1, 8);
        hold(4'b1111, SEG_BAD, 4);
        vectors += 2;
        if (bus.value !== 16'h1234) begin miscompares++; $display("[TB] FAIL multi_value: got %h required 1234", bus.value); end
        if (fd_count - fd0 !== 1) begin miscompares++; $display("[TB] FAIL multi_pulses: got %0d required 1", fd_count - fd0); end
    endtask

    task automatic test_timeout;
        hold(4'b1110, SEG_7, 8);
        hold(4'b1101, SEG_0, 8);
        hold(4'b1111, SEG_BAD, 40);
        vectors += 2;
        if (bus.digit_mask !== 4'b0011) begin miscompares++; $display("[TB] FAIL timeout_early_mask: got %b required 0011", bus.digit_mask); end
        if (bus.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_early_valid: got %b required 1", bus.valid); end
        hold(4'b1111, SEG_BAD, 12);
        vectors += 4;
        if (bus.digit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL timeout_mask: got %b required 0000", bus.digit_mask); end
        if (bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_valid: got %b required 0", bus.valid); end
        if (bus.value !== 16'h1234) begin miscompares++; $display("[TB] FAIL timeout_value: got %h required 1234", bus.value); end
        if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_err: got %b required 0", bus.err); end
    endtask

    task automatic test_reset_midframe;
        int fd0;
        hold(4'b1110, SEG_D, 8);
        hold(4'b1101, SEG_C, 8);
        hold(4'b1011, SEG_B, 8);
        vectors++;
        if (bus.digit_mask !== 4'b0111) begin miscompares++; $display("[TB] FAIL midreset_pre_mask: got %b required 0111", bus.digit_mask); end
        bus.an = 4'b1111;
        bus.seg = SEG_BAD;
        fd0 = fd_count;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors += 5;
        if (bus.value !== 16'h0000) begin miscompares++; $display("[TB] FAIL midreset_value: got %h required 0000", bus.value); end
        if (bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid: got %b required 0", bus.valid); end
        if (bus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_err: got %b required 0", bus.err); end
        if (bus.digit_mask !== 4'b0000) begin miscompares++; $display("[TB] FAIL midreset_mask: got %b required 0000", bus.digit_mask); end
        if (fd_count - fd0 !== 0) begin miscompares++; $display("[TB] FAIL midreset_pulses: got %0d required 0", fd_count - fd0); end
        scan(SEG_4, SEG_3, SEG_2, SEG_1, 0);
        vectors += 3;
        if (bus.value !== 16'h1234) begin miscompares++; $display("[TB] FAIL postreset_value: got %h required 1234", bus.value); end
        if (bus.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL postreset_valid: got %b required 1", bus.valid); end
        if (fd_count - fd0 !== 1) begin miscompares++; $display("[TB] FAIL postreset_pulses: got %0d required 1", fd_count - fd0); end
    endtask

    initial begin
        bus.an  = 4'b1111;
        bus.seg = SEG_BAD;
        rst_n   = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic_scan;
        test_blank_glitch;
        test_bad_digit;
        test_multi_low;
        test_timeout;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
